// File: rtl/io_pmp_pkg.sv
// Shared types for the IO-PMP burst checker: request capture struct, burst/state enums
// and the per-beat AXI address step used by the beat address generator.
package io_pmp_pkg;

    localparam int IO_PMP_PLEN     = 34;
    localparam int IO_PMP_LEN_W    = 8;
    localparam int IO_PMP_MAX_SIZE = 3;

    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FWD,
        ERR
    } chk_state_e;

    // burst is kept as raw bits so the reserved encoding 3 is forwarded unmodified
    typedef struct packed {
        logic [IO_PMP_PLEN-1:0]  addr;
        logic [IO_PMP_LEN_W-1:0] len;
        logic [2:0]              size;
        logic [1:0]              burst;
        pmp_access_t             access;
        priv_lvl_t               priv;
    } io_pmp_req_t;

    function automatic logic [IO_PMP_PLEN-1:0] next_beat_addr(
        input logic [IO_PMP_PLEN-1:0] cur_addr,
        input logic [IO_PMP_PLEN-1:0] lower,
        input logic [IO_PMP_PLEN-1:0] total,
        input logic [2:0]             size,
        input burst_e                 burst
    );
        logic [IO_PMP_PLEN-1:0] step;
        logic [IO_PMP_PLEN-1:0] incr;
        step = IO_PMP_PLEN'(1) << size;
        incr = (cur_addr & ~(step - IO_PMP_PLEN'(1))) + step;
        case (burst)
            FIXED:   next_beat_addr = cur_addr;
            WRAP:    next_beat_addr = (incr == lower + total) ? lower : incr;
            default: next_beat_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/io_pmp_burst_checker_if.sv
// Request / pmp / forward / error bundle of the IO-PMP burst checker.
// The checker connects through the slave modport, its environment through master.
interface io_pmp_burst_checker_if #(
    parameter int PLEN  = io_pmp_pkg::IO_PMP_PLEN,
    parameter int LEN_W = io_pmp_pkg::IO_PMP_LEN_W
);
    import io_pmp_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [PLEN-1:0]   req_addr_i;
    logic [LEN_W-1:0]  req_len_i;
    logic [2:0]        req_size_i;
    logic [1:0]        req_burst_i;
    pmp_access_t       req_access_i;
    priv_lvl_t         req_priv_i;

    logic [PLEN-1:0]   pmp_addr_o;
    pmp_access_t       pmp_access_o;
    priv_lvl_t         pmp_priv_o;
    logic              pmp_allow_i;

    logic              fwd_valid_o;
    logic              fwd_ready_i;
    io_pmp_req_t       fwd_req_o;

    logic              err_valid_o;
    logic              err_ready_i;
    io_pmp_req_t       err_req_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_len_i, req_size_i, req_burst_i,
               req_access_i, req_priv_i, pmp_allow_i, fwd_ready_i, err_ready_i,
        output req_ready_o, pmp_addr_o, pmp_access_o, pmp_priv_o,
               fwd_valid_o, fwd_req_o, err_valid_o, err_req_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_len_i, req_size_i, req_burst_i,
               req_access_i, req_priv_i, pmp_allow_i, fwd_ready_i, err_ready_i,
        input  req_ready_o, pmp_addr_o, pmp_access_o, pmp_priv_o,
               fwd_valid_o, fwd_req_o, err_valid_o, err_req_o
    );

endinterface

// File: rtl/io_pmp_beat_addr.sv
// Combinational next-beat address generator for FIXED / INCR / WRAP AXI bursts.
module io_pmp_beat_addr
    import io_pmp_pkg::*;
(
    input  logic [IO_PMP_PLEN-1:0] cur_addr,
    input  logic [IO_PMP_PLEN-1:0] lower,
    input  logic [IO_PMP_PLEN-1:0] total,
    input  logic [2:0]             size,
    input  burst_e                 burst,
    output logic [IO_PMP_PLEN-1:0] next_addr
);

    assign next_addr = next_beat_addr(cur_addr, lower, total, size, burst);

endmodule

// File: rtl/io_pmp_burst_checker.sv
// Walks every beat of one AXI request through the pmp unit and routes it to fwd or err.
// Define IO_PMP_DENY_CNT_EN to add the deny_cnt_o / deny_addr_o observation ports.
module io_pmp_burst_checker
    import io_pmp_pkg::*;
#(
    parameter int PLEN     = IO_PMP_PLEN,
    parameter int LEN_W    = IO_PMP_LEN_W,
    parameter int MAX_SIZE = IO_PMP_MAX_SIZE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    io_pmp_burst_checker_if.slave  bus
`ifdef IO_PMP_DENY_CNT_EN
    ,
    output logic [31:0]            deny_cnt_o,
    output logic [PLEN-1:0]        deny_addr_o
`endif
);

    chk_state_e       state_q;
    chk_state_e       state_d;
    io_pmp_req_t      req_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [PLEN-1:0]  cur_addr_q;
    logic [PLEN-1:0]  next_addr;
    logic [PLEN-1:0]  size_mask;
    logic [PLEN-1:0]  wrap_total;
    logic [PLEN-1:0]  wrap_lower;
    logic             wrap_len_ok;
    logic             req_illegal;
    logic             last_beat;
    logic             accept;
    logic             step_beat;

    // Everything below is derived from the captured request, never from live req_* inputs
    assign size_mask   = (PLEN'(1) << req_q.size) - PLEN'(1);
    assign wrap_total  = (PLEN'(req_q.len) + PLEN'(1)) << req_q.size;
    assign wrap_lower  = req_q.addr & ~size_mask & ~(wrap_total - PLEN'(1));
    assign wrap_len_ok = (req_q.len == LEN_W'(1)) || (req_q.len == LEN_W'(3)) ||
                         (req_q.len == LEN_W'(7)) || (req_q.len == LEN_W'(15));
    assign req_illegal = (int'(req_q.size) > MAX_SIZE) ||
                         (req_q.burst == 2'd3) ||
                         ((burst_e'(req_q.burst) == WRAP) && !wrap_len_ok);
    assign last_beat   = (beat_cnt_q == req_q.len);
    assign accept      = (state_q == IDLE) && bus.req_valid_i;
    assign step_beat   = (state_q == CHECK) && !req_illegal && bus.pmp_allow_i && !last_beat;

    io_pmp_beat_addr u_beat_addr (
        .cur_addr  (cur_addr_q),
        .lower     (wrap_lower),
        .total     (wrap_total),
        .size      (req_q.size),
        .burst     (burst_e'(req_q.burst)),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid_i) state_d = CHECK;
            CHECK: begin
                if (req_illegal || !bus.pmp_allow_i) begin
                    state_d = ERR;
                end else if (last_beat) begin
                    state_d = FWD;
                end
            end
            FWD:     if (bus.fwd_ready_i) state_d = IDLE;
            ERR:     if (bus.err_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = (state_q == IDLE);
        bus.fwd_valid_o  = (state_q == FWD);
        bus.err_valid_o  = (state_q == ERR);
        bus.fwd_req_o    = req_q;
        bus.err_req_o    = req_q;
        bus.pmp_addr_o   = '0;
        bus.pmp_access_o = ACCESS_NONE;
        bus.pmp_priv_o   = PRIV_LVL_M;
        if (state_q == CHECK) begin
            bus.pmp_addr_o   = cur_addr_q;
            bus.pmp_access_o = req_q.access;
            bus.pmp_priv_o   = req_q.priv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q      <= '0;
            beat_cnt_q <= '0;
            cur_addr_q <= '0;
        end else if (accept) begin
            req_q      <= '{addr:   bus.req_addr_i,
                            len:    bus.req_len_i,
                            size:   bus.req_size_i,
                            burst:  bus.req_burst_i,
                            access: bus.req_access_i,
                            priv:   bus.req_priv_i};
            beat_cnt_q <= '0;
            cur_addr_q <= bus.req_addr_i;
        end else if (step_beat) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            cur_addr_q <= next_addr;
        end
    end

`ifdef IO_PMP_DENY_CNT_EN
    // Illegal requests count as denies; their recorded address is the start address
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deny_cnt_o  <= '0;
            deny_addr_o <= '0;
        end else if ((state_q == CHECK) && (state_d == ERR)) begin
            if (deny_cnt_o != '1) begin
                deny_cnt_o <= deny_cnt_o + 32'd1;
            end
            deny_addr_o <= cur_addr_q;
        end
    end
`endif

endmodule

// File: tb/tb_io_pmp_burst_checker.sv
// Directed self-checking bench for io_pmp_burst_checker with a one-address-deny pmp model.
module tb_io_pmp_burst_checker;
    import io_pmp_pkg::*;

    logic        clk;
    logic        rst;
    logic        denyEn;
    logic [33:0] denyAddr;
    logic        watchForbidden;
    logic        sawForbidden;
    int          checks;
    int          fails;

    io_pmp_burst_checker_if bus ();

    io_pmp_burst_checker dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational pmp stand-in: denies exactly one address when enabled
    assign bus.pmp_allow_i = !(denyEn && (bus.pmp_addr_o == denyAddr));

    always @(negedge clk) begin
        if (watchForbidden && (bus.pmp_addr_o == 34'h1018)) sawForbidden = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic io_pmp_req_t mkReq(input logic [33:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst,
                                          input pmp_access_t access);
        mkReq = '{addr: addr, len: len, size: size, burst: burst, access: access, priv: PRIV_LVL_S};
    endfunction

    task automatic applyStimulus(input string tag, input io_pmp_req_t req);
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, 64'(bus.req_ready_o), 64'd1);
        bus.req_addr_i   = req.addr;
        bus.req_len_i    = req.len;
        bus.req_size_i   = req.size;
        bus.req_burst_i  = req.burst;
        bus.req_access_i = req.access;
        bus.req_priv_i   = req.priv;
        bus.req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i  = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic [33:0] expAddr);
        @(negedge clk);
        checkOutput({tag, "_pmp_addr"}, 64'(bus.pmp_addr_o), 64'(expAddr));
        checkOutput({tag, "_not_ready"}, 64'(bus.req_ready_o), 64'd0);
    endtask

    task automatic checkDone(input string tag, input logic expFwd, input io_pmp_req_t expReq);
        @(negedge clk);
        checkOutput({tag, "_fwd_valid"}, 64'(bus.fwd_valid_o), 64'(expFwd));
        checkOutput({tag, "_err_valid"}, 64'(bus.err_valid_o), 64'(!expFwd));
        if (expFwd) checkOutput({tag, "_fwd_req"}, 64'(bus.fwd_req_o), 64'(expReq));
        else        checkOutput({tag, "_err_req"}, 64'(bus.err_req_o), 64'(expReq));
        bus.fwd_ready_i = expFwd;
        bus.err_ready_i = !expFwd;
        @(posedge clk);
        #1;
        bus.fwd_ready_i = 1'b0;
        bus.err_ready_i = 1'b0;
    endtask

    io_pmp_req_t r;

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        denyEn = 1'b0;
        denyAddr = '0;
        watchForbidden = 1'b0;
        sawForbidden = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_len_i    = '0;
        bus.req_size_i   = '0;
        bus.req_burst_i  = '0;
        bus.req_access_i = ACCESS_NONE;
        bus.req_priv_i   = PRIV_LVL_U;
        bus.fwd_ready_i  = 1'b0;
        bus.err_ready_i  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        checkOutput("rst_fwd_valid", 64'(bus.fwd_valid_o), 64'd0);
        checkOutput("rst_err_valid", 64'(bus.err_valid_o), 64'd0);
        checkOutput("rst_pmp_addr", 64'(bus.pmp_addr_o), 64'd0);
        checkOutput("rst_fwd_req", 64'(bus.fwd_req_o), 64'd0);
        checkOutput("rst_pmp_access", 64'(bus.pmp_access_o), 64'(ACCESS_NONE));
        checkOutput("rst_pmp_priv", 64'(bus.pmp_priv_o), 64'(PRIV_LVL_M));
        rst = 1'b0;

        $display("[TB] INCR burst, all beats allowed");
        r = mkReq(34'h1000, 8'd3, 3'd3, 2'd1, ACCESS_READ);
        applyStimulus("t1", r);
        checkBeat("t1_b0", 34'h1000);
        checkOutput("t1_b0_access", 64'(bus.pmp_access_o), 64'(ACCESS_READ));
        checkOutput("t1_b0_priv", 64'(bus.pmp_priv_o), 64'(PRIV_LVL_S));
        checkBeat("t1_b1", 34'h1008);
        checkBeat("t1_b2", 34'h1010);
        checkBeat("t1_b3", 34'h1018);
        checkDone("t1", 1'b1, r);

        $display("[TB] INCR burst, deny on third beat");
        denyEn = 1'b1;
        denyAddr = 34'h1010;
        sawForbidden = 1'b0;
        watchForbidden = 1'b1;
        applyStimulus("t2", r);
        checkBeat("t2_b0", 34'h1000);
        checkBeat("t2_b1", 34'h1008);
        checkBeat("t2_b2", 34'h1010);
        checkDone("t2", 1'b0, r);
        watchForbidden = 1'b0;
        checkOutput("t2_no_beat3", 64'(sawForbidden), 64'd0);
        denyEn = 1'b0;

        $display("[TB] WRAP burst");
        r = mkReq(34'h1018, 8'd3, 3'd3, 2'd2, ACCESS_READ);
        applyStimulus("t3", r);
        checkBeat("t3_b0", 34'h1018);
        checkBeat("t3_b1", 34'h1000);
        checkBeat("t3_b2", 34'h1008);
        checkBeat("t3_b3", 34'h1010);
        checkDone("t3", 1'b1, r);

        $display("[TB] illegal requests");
        denyEn = 1'b1;
        denyAddr = 34'h3_0000_0000;
        r = mkReq(34'h2000, 8'd3, 3'd4, 2'd1, ACCESS_READ);
        applyStimulus("t4a", r);
        checkBeat("t4a_b0", 34'h2000);
        checkDone("t4a", 1'b0, r);
        r = mkReq(34'h2000, 8'd2, 3'd2, 2'd2, ACCESS_WRITE);
        applyStimulus("t4b", r);
        checkBeat("t4b_b0", 34'h2000);
        checkDone("t4b", 1'b0, r);
        r = mkReq(34'h2040, 8'd1, 3'd0, 2'd3, ACCESS_READ);
        applyStimulus("t4c", r);
        checkBeat("t4c_b0", 34'h2040);
        checkDone("t4c", 1'b0, r);
        denyEn = 1'b0;

        $display("[TB] forward backpressure");
        r = mkReq(34'h3000, 8'd1, 3'd2, 2'd1, ACCESS_WRITE);
        applyStimulus("t5", r);
        checkBeat("t5_b0", 34'h3000);
        checkOutput("t5_b0_access", 64'(bus.pmp_access_o), 64'(ACCESS_WRITE));
        checkBeat("t5_b1", 34'h3004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_hold_valid", 64'(bus.fwd_valid_o), 64'd1);
            checkOutput("t5_hold_req", 64'(bus.fwd_req_o), 64'(r));
            checkOutput("t5_hold_not_ready", 64'(bus.req_ready_o), 64'd0);
            checkOutput("t5_hold_no_err", 64'(bus.err_valid_o), 64'd0);
        end
        checkDone("t5", 1'b1, r);

        $display("[TB] FIXED, unaligned INCR and address carry");
        r = mkReq(34'h6004, 8'd2, 3'd2, 2'd0, ACCESS_READ);
        applyStimulus("t6", r);
        checkBeat("t6_b0", 34'h6004);
        checkBeat("t6_b1", 34'h6004);
        checkBeat("t6_b2", 34'h6004);
        checkDone("t6", 1'b1, r);
        r = mkReq(34'h1003, 8'd1, 3'd2, 2'd1, ACCESS_READ);
        applyStimulus("t7", r);
        checkBeat("t7_b0", 34'h1003);
        checkBeat("t7_b1", 34'h1004);
        checkDone("t7", 1'b1, r);
        r = mkReq(34'h3_FFFF_FFF8, 8'd1, 3'd3, 2'd1, ACCESS_READ);
        applyStimulus("t8", r);
        checkBeat("t8_b0", 34'h3_FFFF_FFF8);
        checkBeat("t8_b1", 34'h0);
        checkDone("t8", 1'b1, r);

        $display("[TB] reset during CHECK");
        r = mkReq(34'h4000, 8'd7, 3'd3, 2'd1, ACCESS_READ);
        applyStimulus("t9", r);
        checkBeat("t9_b0", 34'h4000);
        checkBeat("t9_b1", 34'h4008);
        checkBeat("t9_b2", 34'h4010);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t9_rst_ready", 64'(bus.req_ready_o), 64'd1);
        checkOutput("t9_rst_fwd", 64'(bus.fwd_valid_o), 64'd0);
        checkOutput("t9_rst_err", 64'(bus.err_valid_o), 64'd0);
        checkOutput("t9_rst_req", 64'(bus.fwd_req_o), 64'd0);
        rst = 1'b0;
        r = mkReq(34'h5000, 8'd1, 3'd0, 2'd1, ACCESS_READ);
        applyStimulus("t10", r);
        checkBeat("t10_b0", 34'h5000);
        checkBeat("t10_b1", 34'h5001);
        checkDone("t10", 1'b1, r);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
